// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// datapath mux/ALU select codes and the control-output bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcen;
        logic       illegal_op;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_out_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The controller drives the control
// lines; the datapath supplies opcode, ALU zero flag and memory ready.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcen;
    logic       illegal_op;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, pcen, illegal_op, alusrcb, aluop, pcsrc, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, pcen, illegal_op, alusrcb, aluop, pcsrc, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational control-output decode for the multicycle controller.
// Mealy inputs: mem_ready (FETCH), zero (BRANCH), opcode (DECODE illegal_op).
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_out_t  ctrl
);

    ctrl_out_t raw;

    always_comb begin
        raw = '0;
        case (state)
            S_FETCH: begin
                raw.alusrcb = ALUB_FOUR;
                raw.irwrite = mem_ready;
                raw.pcen    = mem_ready;
            end
            S_DECODE: begin
                raw.alusrcb    = ALUB_IMM_SH2;
                raw.illegal_op = ~is_legal_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                raw.alusrca = 1'b1;
                raw.alusrcb = ALUB_IMM;
            end
            S_MEMRD: raw.iord = 1'b1;
            S_MEMWB: begin
                raw.memtoreg = 1'b1;
                raw.regwrite = 1'b1;
            end
            S_MEMWR: begin
                raw.iord     = 1'b1;
                raw.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                raw.alusrca = 1'b1;
                raw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                raw.regdst   = 1'b1;
                raw.regwrite = 1'b1;
            end
            S_ADDIWB: raw.regwrite = 1'b1;
            S_BRANCH: begin
                raw.alusrca = 1'b1;
                raw.aluop   = ALUOP_SUB;
                raw.pcsrc   = PCSRC_ALUOUT;
                raw.pcen    = zero;
            end
            S_JUMP: begin
                raw.pcsrc = PCSRC_JUMP;
                raw.pcen  = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write enables are suppressed for the whole reset cycle,
    // so a reset landing mid-store never commits a write.
    always_comb begin
        ctrl = raw;
        if (reset) begin
            ctrl.pcen     = 1'b0;
            ctrl.irwrite  = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic; the
// output decode lives in multicycle_ctrl_outdec.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic       illegal_op,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state_o
);

    state_e    state_q, state_d;
    ctrl_out_t ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state     (state_q),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign iord       = ctrl.iord;
    assign memwrite   = ctrl.memwrite;
    assign irwrite    = ctrl.irwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign alusrca    = ctrl.alusrca;
    assign pcen       = ctrl.pcen;
    assign illegal_op = ctrl.illegal_op;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus latency sequences.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (bus.opcode),
        .zero       (bus.zero),
        .mem_ready  (bus.mem_ready),
        .iord       (bus.iord),
        .memwrite   (bus.memwrite),
        .irwrite    (bus.irwrite),
        .regdst     (bus.regdst),
        .memtoreg   (bus.memtoreg),
        .regwrite   (bus.regwrite),
        .alusrca    (bus.alusrca),
        .pcen       (bus.pcen),
        .illegal_op (bus.illegal_op),
        .alusrcb    (bus.alusrcb),
        .aluop      (bus.aluop),
        .pcsrc      (bus.pcsrc),
        .state_o    (bus.state_o)
    );

    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,pcen,illegal_op,alusrcb,aluop,pcsrc}
    localparam logic [14:0] E_F1   = {9'b001000010, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] E_F0   = {9'b000000000, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] E_D    = {9'b000000000, 2'b11, 2'b00, 2'b00};
    localparam logic [14:0] E_DILL = {9'b000000001, 2'b11, 2'b00, 2'b00};
    localparam logic [14:0] E_MA   = {9'b000000100, 2'b10, 2'b00, 2'b00};
    localparam logic [14:0] E_MR   = {9'b100000000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MWB  = {9'b000011000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MW   = {9'b110000000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_MWRS = {9'b100000000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_EX   = {9'b000000100, 2'b00, 2'b10, 2'b00};
    localparam logic [14:0] E_AWB  = {9'b000101000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_IWB  = {9'b000001000, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] E_BR1  = {9'b000000110, 2'b00, 2'b01, 2'b01};
    localparam logic [14:0] E_BR0  = {9'b000000100, 2'b00, 2'b01, 2'b01};
    localparam logic [14:0] E_JMP  = {9'b000000010, 2'b00, 2'b00, 2'b10};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(logic rst, logic [5:0] op, logic z, logic mr,
                               logic [3:0] st, logic [14:0] outs);
        vec_t r;
        r.rst = rst; r.op = op; r.z = z; r.mr = mr; r.st = st; r.outs = outs;
        return r;
    endfunction

    function automatic logic [14:0] dut_outs();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.pcen, bus.illegal_op,
                bus.alusrcb, bus.aluop, bus.pcsrc};
    endfunction

    task automatic check_lat(input logic [5:0] op, input int exp_lat);
        int cyc;
        bus.opcode = op; bus.zero = 1'b0; bus.mem_ready = 1'b1; reset = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.state_o != 4'd0 && cyc < 20);
        n_cmp++;
        if (cyc != exp_lat) begin
            n_bad++;
            $display("FAIL latency op=%b: got %0d cycles, expected %0d", op, cyc, exp_lat);
        end
    endtask

    initial begin
        // reset / LW
        vecs.push_back(v(1, LW, 0, 1, 4'd0, E_F0));
        vecs.push_back(v(0, LW, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, LW, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, LW, 0, 1, 4'd2, E_MA));
        vecs.push_back(v(0, LW, 0, 1, 4'd3, E_MR));
        vecs.push_back(v(0, LW, 0, 1, 4'd4, E_MWB));
        // SW with three wait cycles in MEMWR
        vecs.push_back(v(0, SW, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, SW, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, SW, 0, 1, 4'd2, E_MA));
        vecs.push_back(v(0, SW, 0, 0, 4'd5, E_MW));
        vecs.push_back(v(0, SW, 0, 0, 4'd5, E_MW));
        vecs.push_back(v(0, SW, 0, 0, 4'd5, E_MW));
        vecs.push_back(v(0, SW, 0, 1, 4'd5, E_MW));
        // BEQ taken, then not taken
        vecs.push_back(v(0, BEQ, 1, 1, 4'd0, E_F1));
        vecs.push_back(v(0, BEQ, 1, 1, 4'd1, E_D));
        vecs.push_back(v(0, BEQ, 1, 1, 4'd8, E_BR1));
        vecs.push_back(v(0, BEQ, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, BEQ, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, BEQ, 0, 1, 4'd8, E_BR0));
        // illegal opcode
        vecs.push_back(v(0, BAD, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, BAD, 0, 1, 4'd1, E_DILL));
        // FETCH stall, then RTYPE
        vecs.push_back(v(0, RT, 0, 0, 4'd0, E_F0));
        vecs.push_back(v(0, RT, 0, 0, 4'd0, E_F0));
        vecs.push_back(v(0, RT, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, RT, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, RT, 0, 1, 4'd6, E_EX));
        vecs.push_back(v(0, RT, 0, 1, 4'd7, E_AWB));
        // ADDI, J
        vecs.push_back(v(0, ADDI, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, ADDI, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, ADDI, 0, 1, 4'd9, E_MA));
        vecs.push_back(v(0, ADDI, 0, 1, 4'd10, E_IWB));
        vecs.push_back(v(0, JMP, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, JMP, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, JMP, 0, 1, 4'd11, E_JMP));
        // LW stalled in MEMRD
        vecs.push_back(v(0, LW, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, LW, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, LW, 0, 1, 4'd2, E_MA));
        vecs.push_back(v(0, LW, 0, 0, 4'd3, E_MR));
        vecs.push_back(v(0, LW, 0, 1, 4'd3, E_MR));
        vecs.push_back(v(0, LW, 0, 1, 4'd4, E_MWB));
        // reset in the middle of a held store
        vecs.push_back(v(0, SW, 0, 1, 4'd0, E_F1));
        vecs.push_back(v(0, SW, 0, 1, 4'd1, E_D));
        vecs.push_back(v(0, SW, 0, 1, 4'd2, E_MA));
        vecs.push_back(v(0, SW, 0, 0, 4'd5, E_MW));
        vecs.push_back(v(1, SW, 0, 0, 4'd5, E_MWRS));
        vecs.push_back(v(0, SW, 0, 1, 4'd0, E_F1));

        reset = 1'b1; bus.opcode = LW; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; bus.opcode = vecs[i].op;
            bus.zero = vecs[i].z; bus.mem_ready = vecs[i].mr;
            #1;
            n_cmp++;
            if (bus.state_o !== vecs[i].st) begin
                n_bad++;
                $display("FAIL state[%0d]: got %0d, expected %0d", i, bus.state_o, vecs[i].st);
            end
            n_cmp++;
            if (dut_outs() !== vecs[i].outs) begin
                n_bad++;
                $display("FAIL outs[%0d]: got %b, expected %b", i, dut_outs(), vecs[i].outs);
            end
        end

        // Latency sequences starting from a fresh FETCH
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_lat(LW, 5);
        check_lat(SW, 4);
        check_lat(RT, 4);
        check_lat(ADDI, 4);
        check_lat(BEQ, 3);
        check_lat(JMP, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes happen on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port `opcode`, input, 6 bits: instr[31:26] taken from the instruction register.
REQ-005 The block SHALL have port `zero`, input, 1 bit: the ALU zero flag.
REQ-006 The block SHALL have port `mem_ready`, input, 1 bit: memory completes the current access in this cycle.
REQ-007 The block SHALL have these 1-bit outputs: `iord`, `memwrite`, `irwrite`, `regdst`, `memtoreg`, `regwrite`, `alusrca`, `pcen`, `illegal_op`.
REQ-008 The block SHALL have these 2-bit outputs: `alusrcb`, `aluop`, `pcsrc`.
REQ-009 The block SHALL have output `state_o`, 4 bits: the current state, for debug and verification.

Function
REQ-010 The controller SHALL be a 12-state FSM with these encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
REQ-011 The controller SHALL decode these opcodes:
- LW=100011, SW=101011, RTYPE=000000
- BEQ=000100, ADDI=001000, J=000010
REQ-012 In FETCH:
- outputs SHALL be iord=0, alusrca=0, alusrcb=01 (+4), aluop=00, pcsrc=00;
- irwrite=pcen=mem_ready;
- the FSM SHALL stay in FETCH while mem_ready=0 and move to DECODE when mem_ready=1.
REQ-013 In DECODE:
- outputs SHALL be alusrca=0, alusrcb=11 (sign-extended immediate shifted left by 2; branch target precompute), aluop=00;
- next state SHALL be LW/SW→MEMADR, RTYPE→EXECUTE, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP;
- any other opcode SHALL go to FETCH with illegal_op=1 for that single cycle.
REQ-014 In MEMADR and ADDIEX, outputs SHALL be alusrca=1, alusrcb=10, aluop=00. Next state SHALL be MEMADR→MEMRD (LW) or MEMWR (SW), and ADDIEX→ADDIWB.
REQ-015 In MEMRD, iord SHALL be 1. The FSM SHALL hold until mem_ready=1, then move to MEMWB.
REQ-016 In MEMWB, outputs SHALL be regdst=0, memtoreg=1, regwrite=1; next state SHALL be FETCH.
REQ-017 In MEMWR, outputs SHALL be iord=1, memwrite=1. The FSM SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 In EXECUTE, outputs SHALL be alusrca=1, alusrcb=00, aluop=10, and next state SHALL be ALUWB. In ALUWB, outputs SHALL be regdst=1, memtoreg=0, regwrite=1, and next state SHALL be FETCH.
REQ-019 In ADDIWB, outputs SHALL be regdst=0, memtoreg=0, regwrite=1; next state SHALL be FETCH.
REQ-020 In BRANCH:
- outputs SHALL be alusrca=1, alusrcb=00, aluop=01, pcsrc=01;
- pcen SHALL equal zero;
- next state SHALL be FETCH.
REQ-021 In JUMP, outputs SHALL be pcsrc=10, pcen=1; next state SHALL be FETCH.
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 The outputs SHALL be a combinational decode of state, with mem_ready (FETCH), zero (BRANCH) and opcode (DECODE illegal_op) as the only Mealy inputs.
REQ-024 With mem_ready=1 throughout, instruction latency SHALL be:
- LW 5 cycles;
- SW, RTYPE and ADDI 4 cycles;
- BEQ and J 3 cycles.
REQ-025 Unencoded state values 12–15 SHALL transition to FETCH with all write enables at 0.

Reset
REQ-026 While reset=1, pcen, irwrite, memwrite and regwrite SHALL be forced to 0.
REQ-027 On a clock edge with reset=1, the state SHALL become FETCH regardless of the current state, including a held MEMWR or MEMRD.
REQ-028 After reset releases, the first cycle SHALL present the FETCH outputs.

Structure
REQ-029 Package mips_ctrl_pkg SHALL hold the opcode constants, the state enum (4-bit), the alusrcb/aluop/pcsrc encodings and the output-bundle struct.
REQ-030 The combinational output decode SHALL be one sub-module, multicycle_ctrl_outdec. The state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, then LW with mem_ready=1: states SHALL be 0,1,2,3,4; regwrite=1 and memtoreg=1 only in cycle 5; then back to 0.
- SW with mem_ready low for 3 cycles in MEMWR: memwrite SHALL be held 4 cycles, with state 5 throughout, then 0; regwrite SHALL never be 1.
- BEQ with zero=1, then again with zero=0: pcen=1 and pcsrc=01 in BRANCH for the first, pcen=0 for the second; 3 cycles each.
- Opcode 111111 in DECODE: illegal_op SHALL pulse for 1 cycle, next state 0, no write enable asserted.
- FETCH with mem_ready=0 for 2 cycles: irwrite=pcen=0 and state 0 held; when mem_ready=1, irwrite=pcen=1 for exactly 1 cycle.
- reset asserted mid-MEMWR: memwrite SHALL be 0 in the same cycle, state 0 on the next edge, and FETCH outputs after release.
